// File: rtl/video_pkg.sv
// video_pkg: shared definitions for the video mode sequencer and its helpers.
//   - mode index constants and NUM_MODES
//   - vid_cfg_t: the eight 16-bit timing words, packed
//   - vmc_state_t: sequencer FSM states
//   - mode_valid / mode_cfg: the mode table, usable as constant functions
package video_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_640x480   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_800x600   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_1280x720  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_1920x1080 = 3'd3;
  localparam int unsigned       NUM_MODES      = 4;

  typedef struct packed {
    logic [15:0] hfp;
    logic [15:0] hsyn;
    logic [15:0] hbp;
    logic [15:0] hactive;
    logic [15:0] vfp;
    logic [15:0] vsyn;
    logic [15:0] vbp;
    logic [15:0] vactive;
  } vid_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_FE,
    ST_STOP,
    ST_LOAD,
    ST_SETTLE
  } vmc_state_t;

  function automatic logic mode_valid(input logic [MODE_W-1:0] m);
    return 32'(m) < NUM_MODES;
  endfunction

  // Invalid indices return all-zero timing.
  function automatic vid_cfg_t mode_cfg(input logic [MODE_W-1:0] m);
    vid_cfg_t c;
    c = '0;
    case (m)
      MODE_640x480:   c = '{16'd16,  16'd96,  16'd48,  16'd640,  16'd10, 16'd2, 16'd33, 16'd480};
      MODE_800x600:   c = '{16'd40,  16'd128, 16'd88,  16'd800,  16'd1,  16'd4, 16'd23, 16'd600};
      MODE_1280x720:  c = '{16'd110, 16'd40,  16'd220, 16'd1280, 16'd5,  16'd5, 16'd20, 16'd720};
      MODE_1920x1080: c = '{16'd88,  16'd44,  16'd148, 16'd1920, 16'd4,  16'd5, 16'd36, 16'd1080};
      default:        c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_mode_ctrl_if.sv
// video_mode_ctrl_if: mode-change request handshake.
//   req  : held high by the requester until ack
//   mode : requested mode index, valid while req
//   ack  : one-cycle accept/reject pulse
//   err  : with ack, request rejected (invalid mode)
// master = requester, slave = video_mode_ctrl.
interface video_mode_ctrl_if;
  import video_pkg::*;

  logic              req;
  logic [MODE_W-1:0] mode;
  logic              ack;
  logic              err;

  modport master (output req, output mode, input ack, input err);
  modport slave  (input req, input mode, output ack, output err);
endinterface

// File: rtl/video_mode_rom.sv
// video_mode_rom: combinational mode index -> timing config lookup.
//   mode  in  index to look up
//   cfg   out timing words for that mode (zero when invalid)
//   valid out index names a supported mode
module video_mode_rom
  import video_pkg::*;
(
  input  logic [MODE_W-1:0] mode,
  output vid_cfg_t          cfg,
  output logic              valid
);

  assign cfg   = mode_cfg(mode);
  assign valid = mode_valid(mode);

endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: configuration sequencer for the video timing generator.
// Owns the eight timing words and the generator enable; mode changes are
// applied only at a frame boundary (stop, load, settle, restart) so the
// generator never runs on a half-updated configuration.
//   i_pclk, i_rstn      pixel clock, async active-low reset
//   i_run               1 = generator should run, 0 = stop at next frame end
//   req_if (slave)      mode-change request handshake (req/mode/ack/err)
//   i_frame_end         frame-end pulse from the timing generator
//   o_timeout           pulse: frame-end wait expired, stop forced
//   o_busy              sequencing a stop/load/settle
//   o_mode_cur          mode currently loaded
//   o_tg_en             timing generator enable
//   o_cfg_*             timing configuration words
module video_mode_ctrl
  import video_pkg::*;
#(
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned AUTO_START   = 1,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned FE_TIMEOUT   = 4194304
) (
  input  logic              i_pclk,
  input  logic              i_rstn,
  input  logic              i_run,
  video_mode_ctrl_if.slave  req_if,
  input  logic              i_frame_end,
  output logic              o_timeout,
  output logic              o_busy,
  output logic [MODE_W-1:0] o_mode_cur,
  output logic              o_tg_en,
  output logic [15:0]       o_cfg_hfp,
  output logic [15:0]       o_cfg_hsyn,
  output logic [15:0]       o_cfg_hbp,
  output logic [15:0]       o_cfg_hactive,
  output logic [15:0]       o_cfg_vfp,
  output logic [15:0]       o_cfg_vsyn,
  output logic [15:0]       o_cfg_vbp,
  output logic [15:0]       o_cfg_vactive
);

  localparam logic [22:0]       FE_LAST     = 23'(FE_TIMEOUT - 1);
  localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [MODE_W-1:0] RST_MODE    = MODE_W'(DEFAULT_MODE);
  localparam vid_cfg_t          RST_CFG     = mode_cfg(RST_MODE);
  localparam vmc_state_t        RST_STATE   = (AUTO_START != 0) ? ST_SETTLE : ST_IDLE;

  vmc_state_t        state;
  logic              tg_en, ack, err, timeout, busy;
  logic              pend, boot;
  logic [MODE_W-1:0] pend_mode, mode_cur;
  vid_cfg_t          cfg;
  logic [22:0]       fe_cnt;
  logic [15:0]       st_cnt;

  // One ROM serves both jobs: validating the incoming request (IDLE/RUN)
  // and fetching the latched mode's words (LOAD). They never overlap.
  logic [MODE_W-1:0] rom_mode;
  vid_cfg_t          rom_cfg;
  logic              rom_valid;

  assign rom_mode = (state == ST_LOAD) ? pend_mode : req_if.mode;

  video_mode_rom u_rom (
    .mode  (rom_mode),
    .cfg   (rom_cfg),
    .valid (rom_valid)
  );

  // req is still high in the ack cycle; only the cycle after must be low.
  logic new_req;
  assign new_req = req_if.req && !ack;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= RST_STATE;
      tg_en     <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      pend      <= 1'b0;
      boot      <= 1'b1;
      pend_mode <= RST_MODE;
      mode_cur  <= RST_MODE;
      cfg       <= RST_CFG;
      fe_cnt    <= '0;
      st_cnt    <= '0;
    end else begin
      ack     <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      boot    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (new_req) begin
            ack <= 1'b1;
            if (rom_valid) begin
              pend      <= 1'b1;
              pend_mode <= req_if.mode;
              busy      <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              err <= 1'b1;
            end
          end else if (i_run) begin
            st_cnt <= '0;
            busy   <= 1'b1;
            state  <= ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (new_req) begin
            ack <= 1'b1;
            if (rom_valid) begin
              pend      <= 1'b1;
              pend_mode <= req_if.mode;
              fe_cnt    <= '0;
              busy      <= 1'b1;
              state     <= ST_WAIT_FE;
            end else begin
              err <= 1'b1;
            end
          end else if (!i_run) begin
            fe_cnt <= '0;
            busy   <= 1'b1;
            state  <= ST_WAIT_FE;
          end
        end
        ST_WAIT_FE: begin
          // A real frame end wins over a coincident timeout.
          if (i_frame_end || fe_cnt == FE_LAST) begin
            timeout <= !i_frame_end;
            tg_en   <= 1'b0;
            state   <= ST_STOP;
          end else if (fe_cnt != '1) begin
            fe_cnt <= fe_cnt + 23'd1;
          end
        end
        ST_STOP: begin
          if (pend) begin
            state <= ST_LOAD;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          cfg      <= rom_cfg;
          mode_cur <= pend_mode;
          pend     <= 1'b0;
          if (i_run) begin
            st_cnt <= '0;
            state  <= ST_SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          // Auto-start reset lands here directly; if i_run was low at
          // release, fall back to IDLE on the first edge instead.
          if (boot && !i_run) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (st_cnt == SETTLE_LAST) begin
            busy <= 1'b0;
            if (i_run) begin
              tg_en <= 1'b1;
              state <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            busy <= 1'b1;
            if (st_cnt != '1) st_cnt <= st_cnt + 16'd1;
          end
        end
        default: begin
          tg_en <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_if.ack    = ack;
  assign req_if.err    = err;
  assign o_timeout     = timeout;
  assign o_busy        = busy;
  assign o_mode_cur    = mode_cur;
  assign o_tg_en       = tg_en;
  assign o_cfg_hfp     = cfg.hfp;
  assign o_cfg_hsyn    = cfg.hsyn;
  assign o_cfg_hbp     = cfg.hbp;
  assign o_cfg_hactive = cfg.hactive;
  assign o_cfg_vfp     = cfg.vfp;
  assign o_cfg_vsyn    = cfg.vsyn;
  assign o_cfg_vbp     = cfg.vbp;
  assign o_cfg_vactive = cfg.vactive;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: self-checking bench for video_mode_ctrl.
// Expected acks (err flag) and expected mode at each enable rise are queued
// as stimulus is driven; a negedge monitor pops and compares them.
module tb_video_mode_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic run  = 1'b0;
  logic fe   = 1'b0;
  logic timeout, busy, en;
  logic [2:0]  mode_cur;
  logic [15:0] hfp, hsyn, hbp, hact, vfp, vsyn, vbp, vact;

  int checks = 0;
  int errors = 0;
  logic exp_ack[$];
  int   exp_en[$];
  logic mon_e;
  int   mon_m;
  logic en_prev = 1'b0;
  logic [127:0] cfg_prev = '0;

  video_mode_ctrl_if bus();

  always #5 clk = ~clk;

  video_mode_ctrl #(
    .DEFAULT_MODE (0),
    .AUTO_START   (1),
    .SETTLE_CYC   (16),
    .FE_TIMEOUT   (100)
  ) dut (
    .i_pclk        (clk),
    .i_rstn        (rstn),
    .i_run         (run),
    .req_if        (bus),
    .i_frame_end   (fe),
    .o_timeout     (timeout),
    .o_busy        (busy),
    .o_mode_cur    (mode_cur),
    .o_tg_en       (en),
    .o_cfg_hfp     (hfp),
    .o_cfg_hsyn    (hsyn),
    .o_cfg_hbp     (hbp),
    .o_cfg_hactive (hact),
    .o_cfg_vfp     (vfp),
    .o_cfg_vsyn    (vsyn),
    .o_cfg_vbp     (vbp),
    .o_cfg_vactive (vact)
  );

  function automatic logic [127:0] ref_cfg(input int m);
    case (m)
      0: return {16'd16,  16'd96,  16'd48,  16'd640,  16'd10, 16'd2, 16'd33, 16'd480};
      1: return {16'd40,  16'd128, 16'd88,  16'd800,  16'd1,  16'd4, 16'd23, 16'd600};
      2: return {16'd110, 16'd40,  16'd220, 16'd1280, 16'd5,  16'd5, 16'd20, 16'd720};
      3: return {16'd88,  16'd44,  16'd148, 16'd1920, 16'd4,  16'd5, 16'd36, 16'd1080};
      default: return '0;
    endcase
  endfunction

  function automatic logic [127:0] cur_cfg();
    return {hfp, hsyn, hbp, hact, vfp, vsyn, vbp, vact};
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.ack === 1'b1) begin
        checks++;
        if (exp_ack.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected err=%b", bus.err);
        end else begin
          mon_e = exp_ack.pop_front();
          if (bus.err !== mon_e) begin
            errors++;
            $display("FAIL ack_err got=%b exp=%b", bus.err, mon_e);
          end
        end
      end
      if (en === 1'b1 && en_prev === 1'b0) begin
        checks++;
        if (exp_en.size() == 0) begin
          errors++;
          $display("FAIL en_rise_unexpected mode=%0d", mode_cur);
        end else begin
          mon_m = exp_en.pop_front();
          if (mode_cur !== 3'(mon_m) || cur_cfg() !== ref_cfg(mon_m)) begin
            errors++;
            $display("FAIL en_rise_cfg mode=%0d cfg=%h exp mode=%0d cfg=%h",
                     mode_cur, cur_cfg(), mon_m, ref_cfg(mon_m));
          end
        end
      end
      if (en === 1'b1 && en_prev === 1'b1) begin
        checks++;
        if (cur_cfg() !== cfg_prev) begin
          errors++;
          $display("FAIL cfg_changed_while_en got=%h exp=%h", cur_cfg(), cfg_prev);
        end
      end
    end
    en_prev  = rstn ? en : 1'b0;
    cfg_prev = cur_cfg();
  end

  // Called at a negedge; returns at the negedge where ack was seen.
  task automatic send_req(input logic [2:0] m, input logic e, output int lat);
    exp_ack.push_back(e);
    bus.req  = 1'b1;
    bus.mode = m;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (bus.ack !== 1'b1 && lat < 20);
    bus.req = 1'b0;
  endtask

  task automatic wait_en(input int lim, output int n);
    n = 0;
    while (en !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic pulse_fe();
    fe = 1'b1;
    @(negedge clk);
    fe = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0; run = 1'b1; bus.req = 1'b0; bus.mode = 3'd0;
    #12;
    checks++;
    if ({en, busy, bus.ack, bus.err, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000", {en, busy, bus.ack, bus.err, timeout});
    end
    checks++;
    if (mode_cur !== 3'd0 || cur_cfg() !== ref_cfg(0)) begin
      errors++;
      $display("FAIL reset_cfg mode=%0d cfg=%h exp mode=0 cfg=%h", mode_cur, cur_cfg(), ref_cfg(0));
    end
    exp_en.push_back(0);
    @(negedge clk); rstn = 1'b1;
    wait_en(40, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL autostart_settle got=%0d exp=16", n); end
  endtask

  task automatic test_mode_change();
    int lat, n, bad;
    exp_en.push_back(2);
    send_req(3'd2, 1'b0, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL mc_ack_latency got=%0d exp=1", lat); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (en !== 1'b1 || busy !== 1'b1 || mode_cur !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mc_wait_fe_hold got=%0d bad cycles exp=0", bad); end
    pulse_fe();
    checks++;
    if (en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mc_stop got en=%b busy=%b exp en=0 busy=1", en, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cur_cfg() !== ref_cfg(2) || mode_cur !== 3'd2 || en !== 1'b0) begin
      errors++;
      $display("FAIL mc_load got mode=%0d en=%b cfg=%h exp mode=2 en=0 cfg=%h", mode_cur, en, cur_cfg(), ref_cfg(2));
    end
    wait_en(40, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL mc_settle got=%0d exp=16", n); end
  endtask

  task automatic test_invalid();
    int lat, bad;
    send_req(3'd5, 1'b1, lat);
    checks++;
    if (lat != 1 || bus.err !== 1'b1) begin
      errors++; $display("FAIL inv_ack_err got lat=%0d err=%b exp lat=1 err=1", lat, bus.err);
    end
    pulse_fe();
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (en !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0 || mode_cur !== 3'd2 || cur_cfg() !== ref_cfg(2)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL inv_unchanged got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_timeout();
    int lat, n;
    exp_en.push_back(1);
    send_req(3'd1, 1'b0, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL to_ack_latency got=%0d exp=1", lat); end
    n = 0;
    do begin @(negedge clk); n++; end while (timeout !== 1'b1 && n < 300);
    checks++;
    if (n != 100 || en !== 1'b0) begin
      errors++; $display("FAIL fe_timeout got cyc=%0d en=%b exp cyc=100 en=0", n, en);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cur_cfg() !== ref_cfg(1) || mode_cur !== 3'd1) begin
      errors++; $display("FAIL to_load got mode=%0d cfg=%h exp mode=1 cfg=%h", mode_cur, cur_cfg(), ref_cfg(1));
    end
    wait_en(40, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL to_settle got=%0d exp=16", n); end
  endtask

  task automatic test_back_to_back();
    int lat, n, early;
    exp_en.push_back(3);
    send_req(3'd3, 1'b0, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL b2b_first_ack got=%0d exp=1", lat); end
    exp_ack.push_back(1'b0);
    exp_en.push_back(0);
    bus.req = 1'b1; bus.mode = 3'd0;
    early = 0;
    repeat (3) begin @(negedge clk); if (bus.ack === 1'b1) early++; end
    pulse_fe();
    if (bus.ack === 1'b1) early++;
    n = 0;
    while (en !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (bus.ack === 1'b1) early++;
    end
    checks++;
    if (early != 0 || en !== 1'b1) begin
      errors++; $display("FAIL b2b_held got early=%0d en=%b exp early=0 en=1", early, en);
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL b2b_ack_in_run got ack=%b err=%b exp ack=1 err=0", bus.ack, bus.err);
    end
    bus.req = 1'b0;
    pulse_fe();
    wait_en(40, n);
    checks++;
    if (n != 18) begin errors++; $display("FAIL b2b_settle got=%0d exp=18", n); end
  endtask

  task automatic test_run_stop();
    int bad;
    run = 1'b0;
    bad = 0;
    repeat (4) begin @(negedge clk); if (en !== 1'b1 || busy !== 1'b1) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rs_wait_fe got=%0d bad cycles exp=0", bad); end
    pulse_fe();
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL rs_en got=%b exp=0", en); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mode_cur !== 3'd0) begin
      errors++; $display("FAIL rs_idle got busy=%b mode=%0d exp busy=0 mode=0", busy, mode_cur);
    end
    pulse_fe();
    bad = 0;
    repeat (6) begin @(negedge clk); if (en !== 1'b0 || busy !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rs_idle_hold got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_idle_req();
    int lat, n;
    send_req(3'd7, 1'b1, lat);
    checks++;
    if (lat != 1 || bus.err !== 1'b1) begin
      errors++; $display("FAIL idle_invalid got lat=%0d err=%b exp lat=1 err=1", lat, bus.err);
    end
    @(negedge clk);
    send_req(3'd1, 1'b0, lat);
    checks++;
    if (lat != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL idle_valid got lat=%0d busy=%b exp lat=1 busy=1", lat, busy);
    end
    @(negedge clk);
    checks++;
    if (cur_cfg() !== ref_cfg(1) || mode_cur !== 3'd1 || en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_load got mode=%0d en=%b busy=%b cfg=%h exp mode=1 en=0 busy=0 cfg=%h",
               mode_cur, en, busy, cur_cfg(), ref_cfg(1));
    end
    run = 1'b1;
    exp_en.push_back(1);
    wait_en(40, n);
    checks++;
    if (n != 17) begin errors++; $display("FAIL idle_run_start got=%0d exp=17", n); end
  endtask

  task automatic test_reset_mid_settle();
    int lat, n;
    exp_en.push_back(3);
    send_req(3'd3, 1'b0, lat);
    pulse_fe();
    repeat (5) @(negedge clk);
    checks++;
    if (cur_cfg() !== ref_cfg(3) || en !== 1'b0) begin
      errors++; $display("FAIL rst_pre_cfg got en=%b cfg=%h exp en=0 cfg=%h", en, cur_cfg(), ref_cfg(3));
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || busy !== 1'b0 || mode_cur !== 3'd0 || cur_cfg() !== ref_cfg(0)) begin
      errors++;
      $display("FAIL async_reset got en=%b busy=%b mode=%0d cfg=%h exp en=0 busy=0 mode=0 cfg=%h",
               en, busy, mode_cur, cur_cfg(), ref_cfg(0));
    end
    exp_en.delete();
    exp_en.push_back(0);
    @(negedge clk); rstn = 1'b1;
    wait_en(40, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL rst_restart got=%0d exp=16", n); end
  endtask

  initial begin
    bus.req = 1'b0; bus.mode = 3'd0;
    test_reset();
    test_mode_change();
    test_invalid();
    test_timeout();
    test_back_to_back();
    test_run_stop();
    test_idle_req();
    test_reset_mid_settle();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_ack.size() != 0 || exp_en.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got ack=%0d en=%0d left exp 0", exp_ack.size(), exp_en.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Configuration sequencer for the HDMI video timing generator.
- Owns the eight 16-bit timing configuration words (h/v front porch, sync, back porch, active) and the generator enable.
- Accepts mode-change requests over a req/ack handshake. Applies them only at a frame boundary: stop generator, load new config, hold off for a settle period, restart. The generator never runs with a half-updated configuration.

Parameters:
- DEFAULT_MODE, 0, mode index loaded at reset.
- AUTO_START, 1, 1 = leave reset and start the generator with DEFAULT_MODE.
- SETTLE_CYC, 16, pclk cycles the generator is held disabled after a config load (1..65535).
- FE_TIMEOUT, 4194304, max pclk cycles to wait for a frame-end pulse before forcing the stop.

Ports:
- i_pclk  in  1  pixel clock
- i_rstn  in  1  asynchronous reset, active-low
- i_run  in  1  level; 1 = generator should run, 0 = stop at next frame end
- i_req  in  1  mode-change request; held high until o_ack
- i_mode  in  3  requested mode index, valid while i_req
- o_ack  out  1  one-cycle pulse: request accepted (or rejected, see o_err)
- o_err  out  1  one-cycle pulse coincident with o_ack: invalid mode, request dropped
- o_timeout  out  1  one-cycle pulse: frame-end wait timed out, stop forced
- o_busy  out  1  high in WAIT_FE, STOP, LOAD, SETTLE
- o_mode_cur  out  3  mode currently loaded
- i_frame_end  in  1  one-cycle pulse from timing generator at last pixel of frame
- o_tg_en  out  1  timing generator enable
- o_cfg_hfp, o_cfg_hsyn, o_cfg_hbp, o_cfg_hactive  out  16 each  horizontal config
- o_cfg_vfp, o_cfg_vsyn, o_cfg_vbp, o_cfg_vactive  out  16 each  vertical config

Behaviour:
- Mode table (hfp, hsyn, hbp, hact / vfp, vsyn, vbp, vact):
  - 0 = 640x480: 16, 96, 48, 640 / 10, 2, 33, 480
  - 1 = 800x600: 40, 128, 88, 800 / 1, 4, 23, 600
  - 2 = 1280x720: 110, 40, 220, 1280 / 5, 5, 20, 720
  - 3 = 1920x1080: 88, 44, 148, 1920 / 4, 5, 36, 1080
  - Modes 4-7 are invalid.
- Reset values: o_tg_en = 0; cfg = table[DEFAULT_MODE]; o_mode_cur = DEFAULT_MODE; o_ack, o_err, o_timeout, o_busy = 0.
- State after reset: SETTLE if AUTO_START && i_run, else IDLE.
- FSM states: IDLE, RUN, WAIT_FE, STOP, LOAD, SETTLE.
- IDLE (en = 0):
  - valid req -> ack, latch mode, LOAD.
  - invalid req -> ack + err, stay.
  - i_run = 1 -> SETTLE.
  - req takes priority over i_run in the same cycle.
- RUN (en = 1):
  - valid req -> ack, latch mode, WAIT_FE.
  - invalid req -> ack + err, stay RUN.
  - i_run = 0 -> WAIT_FE with no pending load.
- WAIT_FE (en = 1, timeout counter running):
  - i_frame_end -> STOP.
  - counter reaches FE_TIMEOUT-1 -> o_timeout pulse, STOP.
  - New i_req here is not acked; requester keeps holding.
- STOP (en = 0, one cycle):
  - pending load -> LOAD.
  - else -> IDLE.
- LOAD (en = 0, one cycle): all eight cfg words and o_mode_cur update in the same edge; load flag cleared.
  - Next state SETTLE if i_run, else IDLE.
- SETTLE (en = 0): counts SETTLE_CYC cycles.
  - End of count with i_run = 1 -> RUN.
  - End of count with i_run = 0 -> IDLE.
- Timing: o_tg_en rises on the edge leaving SETTLE. Config is stable for ≥ SETTLE_CYC cycles before en rises and never changes while en = 1.
- Latency: ack is registered, asserted the cycle after req is sampled. i_req must drop the cycle after o_ack or it is treated as a new request.
- i_frame_end outside WAIT_FE is ignored.
- Reset mid-operation: immediate return to reset values; any pending mode is discarded.
- Counters saturate, never wrap. Widths: 23-bit timeout, 16-bit settle.

Decomposition:
- Shared video_pkg:
  - mode index constants (MODE_640x480 ... MODE_1920x1080)
  - NUM_MODES
  - packed cfg struct (8 x 16 bits)
  - FSM state enum
- One sub-module: video_mode_rom. Combinational: mode index -> cfg struct plus valid bit. Reused later by the AVI infoframe builder.

Test Plan:
- Reset with AUTO_START=1, i_run=1 -> o_tg_en=0 for exactly 16 cycles after reset release, then 1; cfg = 16, 96, 48, 640 / 10, 2, 33, 480.
- Running, req mode 2 -> ack one cycle later; en stays 1 until i_frame_end pulse; then en=0, cfg = 110, 40, 220, 1280 / 5, 5, 20, 720 after LOAD; en=1 after 16 settle cycles; o_mode_cur = 2.
- req mode 5 in RUN -> o_ack and o_err high same cycle; cfg, en and o_mode_cur unchanged.
- WAIT_FE with no i_frame_end (FE_TIMEOUT=100 in test) -> o_timeout pulse at cycle 100, en=0, new cfg loaded.
- Second req while o_busy -> no ack until RUN reached, then acked. i_run=0 in RUN -> en drops only after next i_frame_end, state IDLE.
- Assert i_rstn low during SETTLE -> en=0, cfg back to mode 0 immediately (asynchronous).
